stopwatch_cmd_fsm: RTL and testbench

//  Parametrised command FSM for the UART-controlled up-counter.
//  - Merges debounced push-buttons and UART RX command bytes into one event stream.
//  - Drives run / clear / lap-freeze controls to the counter and display path.
//  - Adds over the previous controller: button edge detection, configurable command

---
 rtl/stopwatch_cmd_fsm.sv | 147 ++++++++++++++
 tb/tb_stopwatch_cmd_fsm.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cmd_fsm.sv
// Command FSM for the UART-controlled stopwatch: merges button rising edges and
// UART command bytes into one prioritised event stream driving run/clear/lap.
module stopwatch_cmd_fsm #(
    parameter logic [7:0] CMD_RUN    = 8'h72,
    parameter logic [7:0] CMD_STOP   = 8'h73,
    parameter logic [7:0] CMD_CLR    = 8'h63,
    parameter logic [7:0] CMD_LAP    = 8'h6C,
    parameter bit         CASE_INS   = 1'b1,
    parameter int         CLR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    input  logic       btnr,
    input  logic       btnu,
    input  logic       btnl,
    output logic       o_run_on,
    output logic       o_clr_on,
    output logic       o_lap_on,
    output logic [1:0] o_state,
    output logic       o_ack
);
    localparam int               CNT_W    = $clog2(CLR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_CLR  = 2'b10,
        ST_LAP  = 2'b11
    } state_t;

    typedef enum logic [2:0] {EV_NONE, EV_RUN, EV_STOP, EV_CLR, EV_LAP} event_t;

    // Clearing bit 5 maps an ASCII lower-case letter to its upper-case form.
    function automatic logic cmd_match(input logic [7:0] data, input logic [7:0] cmd);
        return (data == cmd) || (CASE_INS && (data == (cmd & 8'hDF)));
    endfunction

    // Bit order: 0 = btnr (run), 1 = btnu (clear), 2 = btnl (lap).
    logic [2:0] btn_level;
    logic [2:0] btn_edge;
    assign btn_level = {btnl, btnu, btnr};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn_edge
            logic btn_q_reg;
            // Preset to 1 so a button held through reset produces no event.
            always_ff @(posedge clk) begin
                if (reset) btn_q_reg <= 1'b1;
                else       btn_q_reg <= btn_level[gi];
            end
            assign btn_edge[gi] = btn_level[gi] & ~btn_q_reg;
        end
    endgenerate

    event_t uart_ev_next;
    event_t uart_ev_reg;
    event_t event_sel;

    always_comb begin
        uart_ev_next = EV_NONE;
        if (i_rx_done) begin
            if      (cmd_match(i_rx_data, CMD_CLR))  uart_ev_next = EV_CLR;
            else if (cmd_match(i_rx_data, CMD_RUN))  uart_ev_next = EV_RUN;
            else if (cmd_match(i_rx_data, CMD_STOP)) uart_ev_next = EV_STOP;
            else if (cmd_match(i_rx_data, CMD_LAP))  uart_ev_next = EV_LAP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) uart_ev_reg <= EV_NONE;
        else       uart_ev_reg <= uart_ev_next;
    end

    // Any button edge wins over the UART event, even one the state ignores.
    always_comb begin
        event_sel = uart_ev_reg;
        if      (btn_edge[1]) event_sel = EV_CLR;
        else if (btn_edge[0]) event_sel = EV_RUN;
        else if (btn_edge[2]) event_sel = EV_LAP;
    end

    state_t           state_reg;
    logic [CNT_W-1:0] clr_cnt_reg;
    logic             ack_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_STOP;
            clr_cnt_reg <= '0;
            ack_reg     <= 1'b0;
            o_state     <= 2'b00;
            o_run_on    <= 1'b0;
            o_clr_on    <= 1'b0;
            o_lap_on    <= 1'b0;
            o_ack       <= 1'b0;
        end else begin
            ack_reg <= 1'b0;
            case (state_reg)
                ST_STOP: begin
                    if (event_sel == EV_RUN) begin
                        state_reg <= ST_RUN;
                        ack_reg   <= 1'b1;
                    end else if (event_sel == EV_CLR) begin
                        state_reg   <= ST_CLR;
                        clr_cnt_reg <= CLR_LOAD;
                        ack_reg     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (event_sel == EV_RUN || event_sel == EV_STOP) begin
                        state_reg <= ST_STOP;
                        ack_reg   <= 1'b1;
                    end else if (event_sel == EV_LAP) begin
                        state_reg <= ST_LAP;
                        ack_reg   <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (event_sel == EV_LAP) begin
                        state_reg <= ST_RUN;
                        ack_reg   <= 1'b1;
                    end else if (event_sel == EV_RUN || event_sel == EV_STOP) begin
                        state_reg <= ST_STOP;
                        ack_reg   <= 1'b1;
                    end
                end
                ST_CLR: begin
                    // Timed exit is not an event, so it raises no ack.
                    if (clr_cnt_reg <= CNT_ONE) state_reg   <= ST_STOP;
                    else                        clr_cnt_reg <= clr_cnt_reg - CNT_ONE;
                end
                default: state_reg <= ST_STOP;
            endcase

            o_state  <= state_reg;
            o_run_on <= (state_reg == ST_RUN) || (state_reg == ST_LAP);
            o_clr_on <= (state_reg == ST_CLR);
            o_lap_on <= (state_reg == ST_LAP);
            o_ack    <= ack_reg;
        end
    end
endmodule

// File: tb/tb_stopwatch_cmd_fsm.sv
// Bench for stopwatch_cmd_fsm: directed scenarios plus randomized traffic checked
// against a rule-table model of the command protocol.
module tb_stopwatch_cmd_fsm;
    localparam int CLR_CYCLES = 4;
    localparam int M_STOP = 0, M_RUN = 1, M_CLR = 2, M_LAP = 3;
    localparam int E_NONE = 0, E_RUN = 1, E_STOP = 2, E_CLR = 3, E_LAP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       btnr, btnu, btnl;
    logic       run_on, clr_on, lap_on, ack;
    logic [1:0] state;
    logic       c0_run_on, c0_clr_on, c0_lap_on, c0_ack;
    logic [1:0] c0_state;
    logic [5:0] act;

    int n_tests = 0;
    int n_fail  = 0;

    assign act = {state, run_on, clr_on, lap_on, ack};

    stopwatch_cmd_fsm #(.CASE_INS(1'b1), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .btnr(btnr), .btnu(btnu), .btnl(btnl),
        .o_run_on(run_on), .o_clr_on(clr_on), .o_lap_on(lap_on),
        .o_state(state), .o_ack(ack)
    );

    stopwatch_cmd_fsm #(.CASE_INS(1'b0), .CLR_CYCLES(CLR_CYCLES)) dut_cs (
        .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .btnr(btnr), .btnu(btnu), .btnl(btnl),
        .o_run_on(c0_run_on), .o_clr_on(c0_clr_on), .o_lap_on(c0_lap_on),
        .o_state(c0_state), .o_ack(c0_ack)
    );

    always #5 clk = ~clk;

    // Reference model: mode decided at an edge becomes visible one edge later.
    int       m_mode, m_next, m_ev, m_clr_left, m_uart_pend, vis_mode;
    bit       m_ack_next, vis_ack;
    bit [2:0] m_prev;

    function automatic int decode(input logic [7:0] b);
        if (b == 8'h63 || b == 8'h43) return E_CLR;
        if (b == 8'h72 || b == 8'h52) return E_RUN;
        if (b == 8'h73 || b == 8'h53) return E_STOP;
        if (b == 8'h6C || b == 8'h4C) return E_LAP;
        return E_NONE;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_STOP; vis_mode = M_STOP; vis_ack = 0; m_ack_next = 0;
            m_uart_pend = E_NONE; m_prev = 3'b111; m_clr_left = 0;
        end else begin
            vis_mode = m_mode;
            vis_ack  = m_ack_next;
            m_ack_next = 0;
            if      (btnu && !m_prev[1]) m_ev = E_CLR;
            else if (btnr && !m_prev[0]) m_ev = E_RUN;
            else if (btnl && !m_prev[2]) m_ev = E_LAP;
            else                         m_ev = m_uart_pend;
            m_next = m_mode;
            if (m_mode == M_CLR) begin
                m_clr_left--;
                if (m_clr_left == 0) m_next = M_STOP;
            end else if (m_ev == E_RUN) begin
                m_next = (m_mode == M_STOP) ? M_RUN : M_STOP;
            end else if (m_ev == E_STOP) begin
                m_next = M_STOP;
            end else if (m_ev == E_CLR && m_mode == M_STOP) begin
                m_next = M_CLR;
                m_clr_left = CLR_CYCLES;
            end else if (m_ev == E_LAP && m_mode == M_RUN) begin
                m_next = M_LAP;
            end else if (m_ev == E_LAP && m_mode == M_LAP) begin
                m_next = M_RUN;
            end
            if (m_next != m_mode && m_mode != M_CLR) m_ack_next = 1;
            m_mode = m_next;
            m_uart_pend = rx_done ? decode(rx_data) : E_NONE;
            m_prev = {btnl, btnu, btnr};
        end
    end

    function automatic logic [5:0] exp_vec();
        logic [1:0] s;
        s = vis_mode[1:0];
        return {s, vis_mode == M_RUN || vis_mode == M_LAP, vis_mode == M_CLR,
                vis_mode == M_LAP, vis_ack};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte sampled at the first edge; new outputs visible after the third.
    task automatic send_cmd(input logic [7:0] b);
        $display("[TB] rx byte 8'h%h", b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; btnr = 1'b1; btnu = 1'b0; btnl = 1'b0;
        rx_done = 1'b0; rx_data = 8'h00;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (act !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold_btnr: got %b expected %b", act, 6'b0);
            end
        end
        btnr = 1'b0; tick();
        btnr = 1'b1; tick();
        n_tests++;
        if (run_on !== 1'b0) begin
            n_fail++;
            $display("FAIL btnr_latency_early: run_on got %b expected 0", run_on);
        end
        tick();
        n_tests++;
        if ({state, run_on, ack} !== 4'b0111) begin
            n_fail++;
            $display("FAIL btnr_run: got %b expected 0111", {state, run_on, ack});
        end
        tick();
        n_tests++;
        if ({run_on, ack} !== 2'b10) begin
            n_fail++;
            $display("FAIL btnr_ack_width: got %b expected 10", {run_on, ack});
        end
        btnr = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_clear();
        int hi_cnt;
        send_cmd(8'h73);
        n_tests++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL stop_cmd: state got %b expected 00", state);
        end
        $display("[TB] rx byte 8'h63");
        rx_data = 8'h63; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        hi_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            rx_done = (i == 3);
            rx_data = 8'h72;
            tick();
            rx_done = 1'b0;
            if (clr_on === 1'b1) hi_cnt++;
            n_tests++;
            if (clr_on !== ((i >= 2 && i <= 5) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL clr_window_%0d: clr_on got %b", i, clr_on);
            end
            if (i == 2) begin
                n_tests++;
                if ({state, ack} !== 3'b101) begin
                    n_fail++;
                    $display("FAIL clr_entry: got %b expected 101", {state, ack});
                end
            end
        end
        n_tests++;
        if (hi_cnt !== CLR_CYCLES) begin
            n_fail++;
            $display("FAIL clr_length: got %0d expected %0d", hi_cnt, CLR_CYCLES);
        end
        n_tests++;
        if (act !== 6'b0) begin
            n_fail++;
            $display("FAIL clr_exit_stop: got %b expected 000000", act);
        end
    endtask

    task automatic test_lap();
        send_cmd(8'h72);
        n_tests++;
        if ({state, run_on, lap_on} !== 4'b0110) begin
            n_fail++;
            $display("FAIL lap_pre_run: got %b expected 0110", {state, run_on, lap_on});
        end
        send_cmd(8'h6C);
        n_tests++;
        if ({state, run_on, clr_on, lap_on, ack} !== 6'b111011) begin
            n_fail++;
            $display("FAIL lap_enter: got %b expected 111011", act);
        end
        send_cmd(8'h6C);
        n_tests++;
        if ({state, run_on, lap_on} !== 4'b0110) begin
            n_fail++;
            $display("FAIL lap_exit: got %b expected 0110", {state, run_on, lap_on});
        end
        send_cmd(8'h73);
        n_tests++;
        if ({state, run_on, lap_on} !== 4'b0000) begin
            n_fail++;
            $display("FAIL lap_stop: got %b expected 0000", {state, run_on, lap_on});
        end
    endtask

    task automatic test_case_fold();
        reset = 1'b1; tick(); reset = 1'b0;
        send_cmd(8'h52);
        n_tests++;
        if ({state, c0_state} !== 4'b0100) begin
            n_fail++;
            $display("FAIL case_fold_R: got %b expected 0100", {state, c0_state});
        end
        send_cmd(8'h41);
        n_tests++;
        if ({state, c0_state} !== 4'b0100) begin
            n_fail++;
            $display("FAIL case_fold_A_run: got %b expected 0100", {state, c0_state});
        end
        send_cmd(8'h73);
        send_cmd(8'h41);
        n_tests++;
        if ({state, c0_state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL case_fold_A_stop: got %b expected 0000", {state, c0_state});
        end
    endtask

    task automatic test_priority();
        $display("[TB] rx byte 8'h72 with btnu edge");
        rx_data = 8'h72; rx_done = 1'b1;
        tick();
        rx_done = 1'b0; btnu = 1'b1;
        tick();
        tick();
        btnu = 1'b0;
        n_tests++;
        if ({state, clr_on, ack} !== 4'b1011) begin
            n_fail++;
            $display("FAIL prio_btnu_over_uart: got %b expected 1011", {state, clr_on, ack});
        end
        for (int i = 3; i <= 6; i++) begin
            tick();
            n_tests++;
            if (state !== ((i <= 5) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL prio_clr_seq_%0d: state got %b", i, state);
            end
        end
    endtask

    task automatic test_hold_and_reset();
        int acks;
        acks = 0;
        btnr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack === 1'b1) acks++;
        end
        n_tests++;
        if (acks !== 1 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_btnr: acks %0d state %b expected 1 and 01", acks, state);
        end
        btnr = 1'b0; tick();
        btnl = 1'b1; tick(); tick();
        btnl = 1'b0;
        n_tests++;
        if (state !== 2'b11) begin
            n_fail++;
            $display("FAIL btnl_lap: state got %b expected 11", state);
        end
        rx_data = 8'h72; rx_done = 1'b1; tick(); rx_done = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        n_tests++;
        if (act !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_lap: got %b expected 000000", act);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (act !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_discard_%0d: got %b expected 000000", i, act);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pick [10];
        pick = '{8'h72, 8'h73, 8'h63, 8'h6C, 8'h52, 8'h53, 8'h43, 8'h4C, 8'h41, 8'h00};
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) btnr = ~btnr;
            if ($urandom_range(15) == 0) btnu = ~btnu;
            if ($urandom_range(15) == 0) btnl = ~btnl;
            reset = ($urandom_range(599) == 0);
            rx_done = ($urandom_range(5) == 0);
            pick[9] = 8'($urandom);
            rx_data = pick[$urandom_range(9)];
            if (rx_done) $display("[TB] rand cycle %0d rx byte 8'h%h", i, rx_data);
            tick();
            n_tests++;
            if (act !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %b expected %b", i, act, exp_vec());
            end
        end
        reset = 1'b0; rx_done = 1'b0; btnr = 1'b0; btnu = 1'b0; btnl = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_lap();
        test_case_fold();
        test_priority();
        test_hold_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
